// File: rtl/ex_stage_if.sv
// -----------------------------------------------------------------------------
// ex_stage_if
//   Bundles the ID/EX register outputs consumed by the execute stage and the
//   EX/MEM register outputs it produces, plus the stall/redirect feedback.
//
//   Signal names keep the pipeline's historical names. The "_n" suffix on the
//   control inputs names the pipeline stage, not a polarity: all controls are
//   active-high.
//
//   modport master : upstream/ID side (drives operands, sees stall/results)
//   modport slave  : the execute stage itself
//
//   ID/EX side : flush, mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n,
//                branch_n, A, B, alu_select, PC_n2, rs2data, instr_n
//   EX/MEM side: stall, redirect_valid, redirect_pc, alu_result_m, rs2data_m,
//                instr_m, mem_read_m, mem_write_m, mem_to_reg_m
// -----------------------------------------------------------------------------
interface ex_stage_if #(
    parameter int XLEN = 32
);
    // ID/EX register outputs
    logic            flush;
    logic            mem_read_n;
    logic            mem_write_n;
    logic            mem_to_reg_n;
    logic            jumpl_n;
    logic            branch_n;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [3:0]      alu_select;
    logic [XLEN-1:0] PC_n2;
    logic [XLEN-1:0] rs2data;
    logic [31:0]     instr_n;

    // Feedback and EX/MEM register outputs
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] alu_result_m;
    logic [XLEN-1:0] rs2data_m;
    logic [31:0]     instr_m;
    logic            mem_read_m;
    logic            mem_write_m;
    logic            mem_to_reg_m;

    modport master (
        output flush, mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n, branch_n,
               A, B, alu_select, PC_n2, rs2data, instr_n,
        input  stall, redirect_valid, redirect_pc, alu_result_m, rs2data_m,
               instr_m, mem_read_m, mem_write_m, mem_to_reg_m
    );

    modport slave (
        input  flush, mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n, branch_n,
               A, B, alu_select, PC_n2, rs2data, instr_n,
        output stall, redirect_valid, redirect_pc, alu_result_m, rs2data_m,
               instr_m, mem_read_m, mem_write_m, mem_to_reg_m
    );
endinterface

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
//   Execute stage plus EX/MEM pipeline register. Computes the ALU result,
//   resolves conditional branches and JALR, and registers result, store data,
//   instruction and memory controls toward MEM with one cycle of latency.
//
//   Optional macro EX_MUL_EN: when defined, alu_select=10 (MUL) runs on an
//   iterative shift-add multiplier that stalls upstream for N+1 cycles
//   (N = XLEN/MUL_BITS_PER_CYCLE) and sends bubbles downstream meanwhile.
//   When undefined, MUL is a single-cycle op returning 0 and stall is 0.
//
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-low reset
//     ex    - ex_stage_if.slave (ID/EX inputs, EX/MEM outputs, stall/redirect)
// -----------------------------------------------------------------------------
module ex_stage #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic      clk,
    input  logic      reset,
    ex_stage_if.slave ex
);

    if ((XLEN % MUL_BITS_PER_CYCLE) != 0) begin : g_bad_mul_bits
        $error("ex_stage: MUL_BITS_PER_CYCLE must divide XLEN");
    end

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    // Contents of the EX/MEM register.
    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2data;
        logic [31:0]     instr;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            redirect_valid;
        logic [XLEN-1:0] redirect_pc;
    } ex_mem_t;

    // ------------------------------------------------------------------ ALU
    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;

    assign shamt = ex.B[4:0];

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_res = '0;
        case (ex.alu_select)
            ALU_ADD:  alu_res = ex.A + ex.B;
            ALU_SUB:  alu_res = ex.A - ex.B;
            ALU_AND:  alu_res = ex.A & ex.B;
            ALU_OR:   alu_res = ex.A | ex.B;
            ALU_XOR:  alu_res = ex.A ^ ex.B;
            ALU_SLL:  alu_res = ex.A << shamt;
            ALU_SRL:  alu_res = ex.A >> shamt;
            ALU_SRA:  alu_res = $signed(ex.A) >>> shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(ex.A) < $signed(ex.B))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (ex.A < ex.B)};
            // MUL comes from the multiplier (or reads 0 without it); 11-15 are 0.
            default:  alu_res = '0;
        endcase
    end

    // --------------------------------------------------------------- branch
    logic [2:0]      funct3;
    logic            br_taken;
    logic [12:0]     imm13;
    logic [XLEN-1:0] imm_b;

    assign funct3 = ex.instr_n[14:12];
    // B-type immediate: {imm[12], imm[11], imm[10:5], imm[4:1], 0}
    assign imm13  = {ex.instr_n[31], ex.instr_n[7], ex.instr_n[30:25],
                     ex.instr_n[11:8], 1'b0};
    assign imm_b  = {{(XLEN-13){imm13[12]}}, imm13};

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (ex.A == ex.rs2data);
            3'b001:  br_taken = (ex.A != ex.rs2data);
            3'b100:  br_taken = ($signed(ex.A) <  $signed(ex.rs2data));
            3'b101:  br_taken = ($signed(ex.A) >= $signed(ex.rs2data));
            3'b110:  br_taken = (ex.A <  ex.rs2data);
            3'b111:  br_taken = (ex.A >= ex.rs2data);
            default: br_taken = 1'b0;
        endcase
    end

    // Next EX/MEM contents for any single-cycle op. JALR outranks a branch.
    ex_mem_t single_d;

    always_comb begin
        single_d            = '0;
        single_d.alu_result = alu_res;
        single_d.rs2data    = ex.rs2data;
        single_d.instr      = ex.instr_n;
        single_d.mem_read   = ex.mem_read_n;
        single_d.mem_write  = ex.mem_write_n;
        single_d.mem_to_reg = ex.mem_to_reg_n;
        if (ex.jumpl_n) begin
            single_d.alu_result     = ex.PC_n2 + XLEN'(4);
            single_d.redirect_valid = 1'b1;
            single_d.redirect_pc    = (ex.A + ex.B) & ~XLEN'(1);
        end else if (ex.branch_n && br_taken) begin
            single_d.redirect_valid = 1'b1;
            single_d.redirect_pc    = ex.PC_n2 + imm_b;
        end
    end

    // ------------------------------------------------------ EX/MEM register
    ex_mem_t out_q, out_d;
    logic    stall_c;

`ifdef EX_MUL_EN
    localparam int N     = XLEN / MUL_BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e          state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [XLEN-1:0] mcand_q,  mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] prod_q,   prod_d;
    logic [XLEN-1:0] step_sum;
    ex_mem_t         cap_q,    cap_d;
    logic            is_mul;

    assign is_mul = (ex.alu_select == ALU_MUL);

    // Retire MUL_BITS_PER_CYCLE multiplier bits: add each selected, shifted
    // multiplicand into the running low-XLEN product.
    always_comb begin
        step_sum = prod_q;
        for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                step_sum = step_sum + (mcand_q << i);
            end
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cap_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cap_q    <= cap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cap_d    = cap_q;
        out_d    = single_d;
        stall_c  = 1'b0;

        if (ex.flush) begin
            // Squash whatever is in EX, including a multiply in flight.
            state_d = S_IDLE;
            out_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        stall_c  = 1'b1;
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        mcand_d  = ex.A;
                        mplier_d = ex.B;
                        prod_d   = '0;
                        // A MUL never redirects; keep its data/controls for DONE.
                        cap_d                = single_d;
                        cap_d.redirect_valid = 1'b0;
                        cap_d.redirect_pc    = '0;
                        out_d    = '0;
                    end
                end
                S_BUSY: begin
                    stall_c  = 1'b1;
                    out_d    = '0;
                    prod_d   = step_sum;
                    mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
                    mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end
                S_DONE: begin
                    out_d            = cap_q;
                    out_d.alu_result = prod_q;
                    state_d          = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    out_d   = '0;
                end
            endcase
        end
    end
`else
    always_comb begin
        out_d   = ex.flush ? '0 : single_d;
        stall_c = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    // Held low while reset is asserted so every output reads 0 in reset.
    assign ex.stall          = reset & stall_c;
    assign ex.redirect_valid = out_q.redirect_valid;
    assign ex.redirect_pc    = out_q.redirect_pc;
    assign ex.alu_result_m   = out_q.alu_result;
    assign ex.rs2data_m      = out_q.rs2data;
    assign ex.instr_m        = out_q.instr;
    assign ex.mem_read_m     = out_q.mem_read;
    assign ex.mem_write_m    = out_q.mem_write;
    assign ex.mem_to_reg_m   = out_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
//   Directed testbench for ex_stage. A behavioural model of the EX/MEM
//   register (plain arithmetic, multiply as a stall-cycle count plus A*B) is
//   compared against the DUT on every falling edge; literal expectations pin
//   the main scenarios. Works with EX_MUL_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_ex_stage;
    localparam int XLEN = 32;
    localparam int N    = 32;
`ifdef EX_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_stage_if #(.XLEN(XLEN)) bus ();

    ex_stage #(.XLEN(XLEN), .MUL_BITS_PER_CYCLE(1)) dut (
        .clk   (clk),
        .reset (rst_n),
        .ex    (bus)
    );

    // ------------------------------------------------------------ stimulus
    typedef struct {
        logic        flush, mr, mw, mtr, jl, br;
        logic [2:0]  f3;
        logic [3:0]  sel;
        logic [31:0] a, b, pc, rs2, instr;
        int          imm;
    } op_t;

    op_t cur;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o.flush = 1'b0; o.mr = 1'b0; o.mw = 1'b0; o.mtr = 1'b0;
        o.jl = 1'b0; o.br = 1'b0; o.f3 = 3'b0; o.imm = 0;
        o.sel = sel; o.a = a; o.b = b;
        o.pc = 32'h0000_1000; o.rs2 = 32'h5A5A_0001; o.instr = 32'h0000_0033;
        return o;
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
        logic [31:0] iv;
        iv = imm;
        return {iv[12], iv[10:5], 5'd2, 5'd1, f3, iv[4:1], iv[11], 7'b1100011};
    endfunction

    function automatic op_t mk_br(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] rs2, input logic [31:0] pc, input int imm);
        op_t o;
        o = mk(4'd0, a, imm);
        o.br = 1'b1; o.f3 = f3; o.rs2 = rs2; o.pc = pc; o.imm = imm;
        o.instr = enc_b(imm, f3);
        return o;
    endfunction

    task automatic apply(input op_t o);
        cur = o;
        bus.flush        = o.flush;
        bus.mem_read_n   = o.mr;
        bus.mem_write_n  = o.mw;
        bus.mem_to_reg_n = o.mtr;
        bus.jumpl_n      = o.jl;
        bus.branch_n     = o.br;
        bus.A            = o.a;
        bus.B            = o.b;
        bus.alu_select   = o.sel;
        bus.PC_n2        = o.pc;
        bus.rs2data      = o.rs2;
        bus.instr_n      = o.instr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // --------------------------------------------------------------- model
    typedef struct {
        logic [31:0] alu, rs2, instr, rpc;
        logic        mr, mw, mtr, rv;
    } exp_t;

    exp_t exp_q, cap;
    int   phase;   // 0: no multiply; 1..N: stalled cycles after accept; N+1: result cycle

    function automatic exp_t bubble();
        exp_t e;
        e.alu = '0; e.rs2 = '0; e.instr = '0; e.rpc = '0;
        e.mr = 1'b0; e.mw = 1'b0; e.mtr = 1'b0; e.rv = 1'b0;
        return e;
    endfunction

    function automatic exp_t single(input op_t o);
        exp_t e;
        logic taken;
        e = bubble();
        e.rs2 = o.rs2; e.instr = o.instr; e.mr = o.mr; e.mw = o.mw; e.mtr = o.mtr;
        case (o.sel)
            4'd0: e.alu = o.a + o.b;
            4'd1: e.alu = o.a - o.b;
            4'd2: e.alu = o.a & o.b;
            4'd3: e.alu = o.a | o.b;
            4'd4: e.alu = o.a ^ o.b;
            4'd5: e.alu = o.a << o.b[4:0];
            4'd6: e.alu = o.a >> o.b[4:0];
            4'd7: e.alu = $signed(o.a) >>> o.b[4:0];
            4'd8: e.alu = ($signed(o.a) < $signed(o.b)) ? 32'd1 : 32'd0;
            4'd9: e.alu = (o.a < o.b) ? 32'd1 : 32'd0;
            default: e.alu = 32'd0;
        endcase
        case (o.f3)
            3'b000:  taken = (o.a == o.rs2);
            3'b001:  taken = (o.a != o.rs2);
            3'b100:  taken = ($signed(o.a) <  $signed(o.rs2));
            3'b101:  taken = ($signed(o.a) >= $signed(o.rs2));
            3'b110:  taken = (o.a <  o.rs2);
            3'b111:  taken = (o.a >= o.rs2);
            default: taken = 1'b0;
        endcase
        if (o.jl) begin
            e.alu = o.pc + 32'd4; e.rv = 1'b1; e.rpc = (o.a + o.b) & 32'hFFFF_FFFE;
        end else if (o.br && taken) begin
            e.rv = 1'b1; e.rpc = o.pc + o.imm;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q = bubble(); phase = 0;
        end else if (cur.flush) begin
            exp_q = bubble(); phase = 0;
        end else if (MUL_ON && phase == 0 && cur.sel == 4'd10) begin
            cap = single(cur);
            cap.alu = cur.a * cur.b; cap.rv = 1'b0; cap.rpc = '0;
            exp_q = bubble(); phase = 1;
        end else if (phase >= 1 && phase <= N) begin
            exp_q = bubble(); phase++;
        end else if (phase == N + 1) begin
            exp_q = cap; phase = 0;
        end else begin
            exp_q = single(cur);
        end
    end

    function automatic logic exp_stall();
        return MUL_ON && !cur.flush &&
               ((phase >= 1 && phase <= N) || (phase == 0 && cur.sel == 4'd10));
    endfunction

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("stall",          {31'b0, bus.stall},          {31'b0, exp_stall()});
            check("alu_result_m",   bus.alu_result_m,            exp_q.alu);
            check("rs2data_m",      bus.rs2data_m,               exp_q.rs2);
            check("instr_m",        bus.instr_m,                 exp_q.instr);
            check("mem_read_m",     {31'b0, bus.mem_read_m},     {31'b0, exp_q.mr});
            check("mem_write_m",    {31'b0, bus.mem_write_m},    {31'b0, exp_q.mw});
            check("mem_to_reg_m",   {31'b0, bus.mem_to_reg_m},   {31'b0, exp_q.mtr});
            check("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, exp_q.rv});
            check("redirect_pc",    bus.redirect_pc,             exp_q.rpc);
        end
    end

    // -------------------------------------------------------- directed run
    typedef struct { logic [3:0] sel; logic [31:0] a, b, r; } alu_vec_t;
    alu_vec_t av [11] = '{
        '{4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
        '{4'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
        '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
        '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
        '{4'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F},
        '{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F},
        '{4'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002},
        '{4'd6,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
        '{4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
        '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
        '{4'd12, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000}
    };

    typedef struct { logic [2:0] f3; logic [31:0] a, rs2; int imm; logic rv; logic [31:0] rpc; } br_vec_t;
    br_vec_t bv [6] = '{
        '{3'b000, 32'd9,          32'd9,          16,    1'b1, 32'h0000_0110},
        '{3'b000, 32'd9,          32'd8,          16,    1'b0, 32'h0000_0000},
        '{3'b100, 32'hFFFF_FFFF,  32'd1,          -8,    1'b1, 32'h0000_00F8},
        '{3'b110, 32'hFFFF_FFFF,  32'd1,          -8,    1'b0, 32'h0000_0000},
        '{3'b101, 32'd1,          32'hFFFF_FFFF,  4094,  1'b1, 32'h0000_10FE},
        '{3'b010, 32'd3,          32'd3,          16,    1'b0, 32'h0000_0000}
    };

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod);
        op_t o;
        int  n;
        o = mk(4'd10, a, b);
        o.mtr = 1'b1; o.instr = 32'h0262_8233;
        apply(o);
        n = 0;
        while (bus.stall === 1'b1 && n < 100) begin
            n++;
            step();
        end
        check("mul_stall_cycles", n, MUL_ON ? 32'd33 : 32'd0);
        step();
        check("mul_result", bus.alu_result_m, MUL_ON ? prod : 32'd0);
        check("mul_mem_to_reg", {31'b0, bus.mem_to_reg_m}, 32'd1);
        check("mul_instr", bus.instr_m, 32'h0262_8233);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        op_t o;
        o = mk(4'd0, 32'd5, 32'd3);
        o.mr = 1'b1; o.mtr = 1'b1; o.instr = 32'h0031_0233; o.rs2 = 32'h0000_00AB;
        apply(o);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_alu",    bus.alu_result_m, 32'd0);
        check("reset_rv",     {31'b0, bus.redirect_valid}, 32'd0);
        check("reset_rpc",    bus.redirect_pc, 32'd0);
        check("reset_mr",     {31'b0, bus.mem_read_m}, 32'd0);
        check("reset_instr",  bus.instr_m, 32'd0);
        check("reset_stall",  {31'b0, bus.stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        step();
        check("add_result", bus.alu_result_m, 32'd8);
        check("add_mr",     {31'b0, bus.mem_read_m}, 32'd1);
        check("add_mw",     {31'b0, bus.mem_write_m}, 32'd0);
        check("add_mtr",    {31'b0, bus.mem_to_reg_m}, 32'd1);
        check("add_instr",  bus.instr_m, 32'h0031_0233);
        check("add_rs2",    bus.rs2data_m, 32'h0000_00AB);
        check("add_stall",  {31'b0, bus.stall}, 32'd0);

        // Asynchronous reset pulse in the middle of a cycle.
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_alu",   bus.alu_result_m, 32'd0);
        check("async_rst_mr",    {31'b0, bus.mem_read_m}, 32'd0);
        check("async_rst_instr", bus.instr_m, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            apply(mk(av[i].sel, av[i].a, av[i].b));
            step();
            check($sformatf("alu_sel%0d", av[i].sel), bus.alu_result_m, av[i].r);
        end

        for (int i = 0; i < 6; i++) begin
            apply(mk_br(bv[i].f3, bv[i].a, bv[i].rs2, 32'h0000_0100, bv[i].imm));
            step();
            check($sformatf("br%0d_valid", i), {31'b0, bus.redirect_valid}, {31'b0, bv[i].rv});
            if (bv[i].rv) check($sformatf("br%0d_pc", i), bus.redirect_pc, bv[i].rpc);
            apply(mk(4'd0, 32'd1, 32'd1));
            step();
            check($sformatf("br%0d_pulse_end", i), {31'b0, bus.redirect_valid}, 32'd0);
        end

        o = mk(4'd0, 32'h0000_0203, 32'd0);
        o.jl = 1'b1; o.pc = 32'h0000_0040;
        apply(o);
        step();
        check("jalr_valid", {31'b0, bus.redirect_valid}, 32'd1);
        check("jalr_pc",    bus.redirect_pc, 32'h0000_0202);
        check("jalr_link",  bus.alu_result_m, 32'h0000_0044);

        // JALR and branch together: JALR target wins.
        o = mk_br(3'b000, 32'h0000_0100, 32'h0000_0100, 32'h0000_0040, 64);
        o.jl = 1'b1; o.b = 32'h0000_0011;
        apply(o);
        step();
        check("jalr_over_br_pc", bus.redirect_pc, 32'h0000_0110);

        run_mul(32'd7, 32'd6, 32'd42);
        run_mul(32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Flush a multiply in flight.
        o = mk(4'd10, 32'd7, 32'd6);
        o.mr = 1'b1;
        apply(o);
        repeat (10) step();
        o.flush = 1'b1;
        apply(o);
        check("flush_stall_drop", {31'b0, bus.stall}, 32'd0);
        step();
        check("flush_bubble_alu", bus.alu_result_m, 32'd0);
        check("flush_bubble_mr",  {31'b0, bus.mem_read_m}, 32'd0);
        check("flush_bubble_rv",  {31'b0, bus.redirect_valid}, 32'd0);
        apply(mk(4'd0, 32'd5, 32'd3));
        check("flush_idle_stall", {31'b0, bus.stall}, 32'd0);
        step();
        check("flush_then_add", bus.alu_result_m, 32'd8);

        // Reset in the middle of a multiply.
        apply(mk(4'd10, 32'd9, 32'd9));
        repeat (5) step();
        #1 rst_n = 1'b0;
        #1;
        check("mulrst_stall", {31'b0, bus.stall}, 32'd0);
        check("mulrst_alu",   bus.alu_result_m, 32'd0);
        rst_n = 1'b1;
        apply(mk(4'd0, 32'd2, 32'd2));
        step();
        check("mulrst_then_add", bus.alu_result_m, 32'd4);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage plus EX/MEM pipeline register.
- Consumes the ID/EX register outputs: operands, ALU select, control bits, PC and instruction.
- Computes the ALU result and resolves branches and JALR, then registers everything toward MEM.
- Contains an iterative shift-add multiplier. It stalls upstream while busy and issues a bubble downstream.

Parameters:
XLEN, 32, datapath width
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per cycle; must divide XLEN; N = XLEN/MUL_BITS_PER_CYCLE

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  squash the current EX op (from hazard unit)
mem_read_n  input  1  load control
mem_write_n  input  1  store control
mem_to_reg_n  input  1  writeback select control
jumpl_n  input  1  JALR
branch_n  input  1  conditional branch
A  input  XLEN  rs1 operand
B  input  XLEN  second operand (rs2 or immediate)
alu_select  input  4  ALU op
PC_n2  input  XLEN  PC of the instruction
rs2data  input  XLEN  rs2 value (store data, branch compare)
instr_n  input  32  instruction word
stall  output  1  hold ID/EX and upstream stages
redirect_valid  output  1  taken branch/jump, registered
redirect_pc  output  XLEN  target PC, registered
alu_result_m  output  XLEN  result to MEM
rs2data_m  output  XLEN  store data to MEM
instr_m  output  32  instruction to MEM
mem_read_m  output  1  registered control
mem_write_m  output  1  registered control
mem_to_reg_m  output  1  registered control

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM to IDLE, multiplier counter 0.
- alu_select encoding (combinational ALU):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
  - 8 SLT signed, 9 SLTU; result 1/0 zero-extended.
  - 10 MUL (low XLEN bits of A*B).
  - 11–15 yield 0.
  - All arithmetic wraps modulo 2^XLEN.
- jumpl_n=1:
  - alu_result = PC_n2+4.
  - Target = (A+B) & ~1.
  - Always taken.
- branch_n=1:
  - Condition from instr_n[14:12], comparing A with rs2data: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Other funct3 values are never taken.
  - Target = PC_n2 + sign-extended B-type immediate from instr_n.
  - Both branch_n and jumpl_n set: jumpl_n wins.
- Single-cycle ops: results and control are registered on the next rising edge, so latency is 1. redirect_valid pulses for exactly one cycle.
- FSM states IDLE, BUSY, DONE:
  - IDLE, alu_select=10, flush=0: latch A and B, counter=0, go to BUSY. Output register loads a bubble (all controls 0, redirect_valid 0, data 0).
  - BUSY: retire MUL_BITS_PER_CYCLE bits per cycle. When counter=N-1, go to DONE. Output register holds the bubble.
  - DONE: output register loads the product with the captured control bits, then go to IDLE.
- stall = (IDLE and alu_select=10 and !flush) or BUSY. stall is 0 in DONE.
- Upstream holds inputs stable while stall=1. The MUL occupies N+1 stalled cycles and its result appears at the edge leaving DONE.
- flush (highest priority after reset), any state:
  - Next edge loads a bubble and redirect_valid=0.
  - FSM returns to IDLE; an in-flight multiply is discarded.
  - stall deasserts combinationally.
- Back-to-back MULs: the second is accepted in the IDLE cycle following DONE.
- Reset asserted mid-multiply: immediate IDLE with outputs cleared; no partial result escapes.

Optional Feature:
EX_MUL_EN
- Defined: iterative multiplier, FSM and stall logic present as above.
- Undefined:
  - alu_select=10 behaves as a single-cycle op with result 0.
  - stall is tied 0 and the FSM is not instantiated.

Test Plan:
- Release reset; A=5, B=3, sel=0 -> next edge alu_result_m=8, all controls mirror inputs, stall=0.
- Pulse reset mid-cycle -> all outputs 0 immediately, asynchronously.
- sel=1, A=0, B=1 -> alu_result_m=0xFFFFFFFF.
- sel=7, A=0x80000000, B=4 -> 0xF8000000.
- branch_n=1, funct3=000, A=rs2data=9, PC_n2=0x100, imm=+16 -> redirect_valid=1 for one cycle, redirect_pc=0x110.
- Same setup with rs2data=8 -> redirect_valid=0.
- jumpl_n=1, A=0x203, B=0, PC_n2=0x40 -> redirect_pc=0x202, alu_result_m=0x44.
- MUL A=7, B=6, default params:
  - stall high for 33 cycles; bubbles output meanwhile.
  - alu_result_m=42 on the following edge.
  - With EX_MUL_EN undefined: result 0, stall never set.
- MUL in flight, flush at cycle 10 -> stall drops the same cycle, next output is a bubble, FSM is IDLE, and a following ADD completes normally.
